// File: rtl/vga_clock_digits_pkg.sv
`timescale 1ns/1ps
// Shared constants and helpers for the seven-segment clock renderer:
// segment bit indices, BCD glyph table, colour levels and screen bounds.
package vga_clock_digits_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [3:0] COLOUR_ON  = 4'hF;
  localparam logic [3:0] COLOUR_OFF = 4'h0;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  // All coordinate arithmetic is done at this width.
  localparam int CW = 11;

  // Segment mask, bit0..6 = a..g; codes 10-15 draw nothing.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h67;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  // Left edge of the digit drawn in screen column col (0 = leftmost).
  function automatic int digit_left(input int col, input int x0, input int pitch,
                                    input int group, input int gap);
    return x0 + col * pitch + (col / group) * gap;
  endfunction

endpackage

// File: rtl/vga_clock_digits_if.sv
`timescale 1ns/1ps
// Pixel-stream bundle between the timing source and the digit renderer.
interface vga_clock_digits_if #(parameter int N_DIGITS = 6);

  logic                    i_pix_stb;
  logic [9:0]              i_x;
  logic [8:0]              i_y;
  logic [4*N_DIGITS-1:0]   i_bcd;
  logic [N_DIGITS-1:0]     i_blank;
  logic [N_DIGITS-1:0]     i_hit;
  logic                    i_hs;
  logic                    i_vs;
  logic [3:0]              o_r;
  logic [3:0]              o_g;
  logic [3:0]              o_b;
  logic                    o_hs;
  logic                    o_vs;

  modport master (
    output i_pix_stb, i_x, i_y, i_bcd, i_blank, i_hit, i_hs, i_vs,
    input  o_r, o_g, o_b, o_hs, o_vs
  );

  modport slave (
    input  i_pix_stb, i_x, i_y, i_bcd, i_blank, i_hit, i_hs, i_vs,
    output o_r, o_g, o_b, o_hs, o_vs
  );

endinterface

// File: rtl/vga_clock_digits_seg7_glyph.sv
`timescale 1ns/1ps
// Combinational seven-segment hit test: is local pixel (u,v) on a lit segment?
// The caller guarantees (u,v) lies inside the digit box.
module seg7_glyph
  import vga_clock_digits_pkg::*;
#(
  parameter int SEG_W   = 15,
  parameter int SEG_LEN = 28
) (
  input  logic [CW-1:0] u_i,
  input  logic [CW-1:0] v_i,
  input  logic [6:0]    seg_i,
  output logic          lit_o
);

  localparam logic [CW-1:0] W      = CW'(SEG_W);
  localparam logic [CW-1:0] DW     = CW'(2 * SEG_W + SEG_LEN);
  localparam logic [CW-1:0] RIGHT  = CW'(SEG_W + SEG_LEN);
  localparam logic [CW-1:0] MID_LO = CW'(SEG_W + SEG_LEN);
  localparam logic [CW-1:0] MID_HI = CW'(2 * SEG_W + SEG_LEN);
  localparam logic [CW-1:0] BOT    = CW'(2 * SEG_W + 2 * SEG_LEN);

  logic [6:0] hit;

  always_comb begin
    hit        = '0;
    hit[SEG_A] = (u_i < DW) && (v_i < W);
    hit[SEG_B] = (u_i >= RIGHT) && (v_i < MID_HI);
    hit[SEG_C] = (u_i >= RIGHT) && (v_i >= MID_LO);
    hit[SEG_D] = (u_i < DW) && (v_i >= BOT);
    hit[SEG_E] = (u_i < W) && (v_i >= MID_LO);
    hit[SEG_F] = (u_i < W) && (v_i < MID_HI);
    hit[SEG_G] = (u_i < DW) && (v_i >= MID_LO) && (v_i < MID_HI);
    lit_o      = |(hit & seg_i);
  end

endmodule

// File: rtl/vga_clock_digits.sv
`timescale 1ns/1ps
// Seven-segment clock renderer on a 640x480 pixel stream: double-buffered digits,
// blinking colons, per-digit red hit flash, two-strobe registered pixel pipeline.
module vga_clock_digits
  import vga_clock_digits_pkg::*;
#(
  parameter int N_DIGITS     = 6,
  parameter int GROUP        = 2,
  parameter int X0           = 53,
  parameter int Y0           = 180,
  parameter int SEG_W        = 15,
  parameter int SEG_LEN      = 28,
  parameter int DIGIT_PITCH  = 69,
  parameter int COLON_GAP    = 28,
  parameter int FLASH_FRAMES = 30,
  parameter int BLINK_FRAMES = 30
) (
  input  logic               CLK,
  input  logic               RST_BTN,
  vga_clock_digits_if.slave  bus
);

  localparam int DW         = 2 * SEG_W + SEG_LEN;
  localparam int DH         = 3 * SEG_W + 2 * SEG_LEN;
  localparam int N_GROUPS   = (N_DIGITS + GROUP - 1) / GROUP;
  localparam int N_COLONS   = N_GROUPS - 1;
  localparam int N_DOT_BITS = (N_COLONS > 0) ? N_COLONS : 1;
  localparam int RIGHT_EDGE = digit_left(N_DIGITS - 1, X0, DIGIT_PITCH, GROUP, COLON_GAP) + DW;
  // Dot sits centred in the gap between the last digit of one group and the first of the next.
  localparam int DOT_OFS    = DW + (DIGIT_PITCH + COLON_GAP - DW - SEG_W) / 2;
  localparam int DOT_UP_Y   = Y0 + SEG_W + SEG_LEN / 2;
  localparam int DOT_LO_Y   = Y0 + 2 * SEG_W + SEG_LEN + SEG_LEN / 2;
  localparam logic [7:0] FLASH_LOAD = 8'(FLASH_FRAMES);
  localparam logic [7:0] BLINK_LAST = 8'((BLINK_FRAMES > 0) ? BLINK_FRAMES - 1 : 0);

  if (RIGHT_EDGE > H_ACTIVE || Y0 + DH > V_ACTIVE || DIGIT_PITCH < DW ||
      FLASH_FRAMES < 1 || FLASH_FRAMES > 255 || BLINK_FRAMES > 255) begin : g_bad_params
    $error("vga_clock_digits: digit boxes leave the screen or counter ranges invalid");
  end

  logic [CW-1:0] x_ext, y_ext;
  logic          frame_start, in_rows;

  assign x_ext       = {1'b0, bus.i_x};
  assign y_ext       = {2'b00, bus.i_y};
  assign frame_start = bus.i_pix_stb && (bus.i_x == '0) && (bus.i_y == '0);
  assign in_rows     = (y_ext >= CW'(Y0)) && (y_ext < CW'(Y0 + DH));

  logic [4*N_DIGITS-1:0] shadow_bcd_q, shadow_bcd_d;
  logic [N_DIGITS-1:0]   shadow_blank_q, shadow_blank_d;
  logic [7:0]            flash_cnt_q [N_DIGITS];
  logic [7:0]            flash_cnt_d [N_DIGITS];
  logic [N_DIGITS-1:0]   flash_nz;
  logic [7:0]            blink_cnt_q, blink_cnt_d;
  logic                  colon_on_q, colon_on_d;

  logic [N_DIGITS-1:0]          box_d;
  logic [N_DIGITS-1:0][CW-1:0]  u_d;
  logic [N_DIGITS-1:0][6:0]     seg_d;
  logic [CW-1:0]                v_d;
  logic [N_DOT_BITS-1:0]        dot_hit;
  logic                         colon_d;

  logic [N_DIGITS-1:0]          s1_box_q;
  logic [N_DIGITS-1:0][CW-1:0]  s1_u_q;
  logic [CW-1:0]                s1_v_q;
  logic [N_DIGITS-1:0][6:0]     s1_seg_q;
  logic [N_DIGITS-1:0]          s1_flash_q;
  logic                         s1_colon_q;
  logic [1:0]                   hs_q, vs_q;

  logic [N_DIGITS-1:0] glyph_lit, digit_lit;
  logic                red_on, green_on;
  logic [3:0]          r_q, r_d, g_q, g_d;

  assign shadow_bcd_d   = frame_start ? bus.i_bcd   : shadow_bcd_q;
  assign shadow_blank_d = frame_start ? bus.i_blank : shadow_blank_q;

  // A hit on the same clock as frame_start reloads rather than decrements.
  always_comb begin
    for (int k = 0; k < N_DIGITS; k++) begin
      flash_nz[k]    = (flash_cnt_q[k] != 8'd0);
      flash_cnt_d[k] = flash_cnt_q[k];
      if (bus.i_hit[k]) begin
        flash_cnt_d[k] = FLASH_LOAD;
      end else if (frame_start && flash_nz[k]) begin
        flash_cnt_d[k] = flash_cnt_q[k] - 8'd1;
      end
    end
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    colon_on_d  = colon_on_q;
    if (BLINK_FRAMES != 0 && frame_start) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = 8'd0;
        colon_on_d  = ~colon_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'd1;
      end
    end
  end

  for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
    localparam int LEFT = digit_left(N_DIGITS - 1 - k, X0, DIGIT_PITCH, GROUP, COLON_GAP);
    assign box_d[k] = in_rows && (x_ext >= CW'(LEFT)) && (x_ext < CW'(LEFT + DW));
    assign u_d[k]   = x_ext - CW'(LEFT);
    assign seg_d[k] = shadow_blank_q[k] ? 7'd0 : bcd_to_seg(shadow_bcd_q[4*k +: 4]);

    seg7_glyph #(.SEG_W(SEG_W), .SEG_LEN(SEG_LEN)) u_glyph (
      .u_i   (s1_u_q[k]),
      .v_i   (s1_v_q),
      .seg_i (s1_seg_q[k]),
      .lit_o (glyph_lit[k])
    );
  end

  if (N_COLONS > 0) begin : g_colons
    for (genvar c = 0; c < N_COLONS; c++) begin : g_colon
      localparam int DOT_X =
        digit_left(GROUP * (c + 1) - 1, X0, DIGIT_PITCH, GROUP, COLON_GAP) + DOT_OFS;
      assign dot_hit[c] = (x_ext >= CW'(DOT_X)) && (x_ext < CW'(DOT_X + SEG_W)) &&
                          (((y_ext >= CW'(DOT_UP_Y)) && (y_ext < CW'(DOT_UP_Y + SEG_W))) ||
                           ((y_ext >= CW'(DOT_LO_Y)) && (y_ext < CW'(DOT_LO_Y + SEG_W))));
    end
  end else begin : g_no_colon
    assign dot_hit = '0;
  end

  assign v_d     = y_ext - CW'(Y0);
  assign colon_d = colon_on_q && (|dot_hit);

  assign digit_lit = s1_box_q & glyph_lit;
  assign red_on    = |(digit_lit & s1_flash_q);
  assign green_on  = (|digit_lit) || s1_colon_q;
  assign r_d       = red_on ? COLOUR_ON : COLOUR_OFF;
  assign g_d       = (!red_on && green_on) ? COLOUR_ON : COLOUR_OFF;

  always_ff @(posedge CLK or negedge RST_BTN) begin
    if (!RST_BTN) begin
      shadow_bcd_q   <= '0;
      shadow_blank_q <= '1;
      for (int k = 0; k < N_DIGITS; k++) flash_cnt_q[k] <= 8'd0;
      blink_cnt_q    <= 8'd0;
      colon_on_q     <= 1'b1;
      s1_box_q       <= '0;
      s1_u_q         <= '0;
      s1_v_q         <= '0;
      s1_seg_q       <= '0;
      s1_flash_q     <= '0;
      s1_colon_q     <= 1'b0;
      hs_q           <= '0;
      vs_q           <= '0;
      r_q            <= '0;
      g_q            <= '0;
    end else begin
      shadow_bcd_q   <= shadow_bcd_d;
      shadow_blank_q <= shadow_blank_d;
      for (int k = 0; k < N_DIGITS; k++) flash_cnt_q[k] <= flash_cnt_d[k];
      blink_cnt_q    <= blink_cnt_d;
      colon_on_q     <= colon_on_d;
      if (bus.i_pix_stb) begin
        s1_box_q   <= box_d;
        s1_u_q     <= u_d;
        s1_v_q     <= v_d;
        s1_seg_q   <= seg_d;
        s1_flash_q <= flash_nz;
        s1_colon_q <= colon_d;
        hs_q       <= {hs_q[0], bus.i_hs};
        vs_q       <= {vs_q[0], bus.i_vs};
        r_q        <= r_d;
        g_q        <= g_d;
      end
    end
  end

  assign bus.o_r  = r_q;
  assign bus.o_g  = g_q;
  assign bus.o_b  = COLOUR_OFF;
  assign bus.o_hs = hs_q[1];
  assign bus.o_vs = vs_q[1];

endmodule

// File: tb/tb_vga_clock_digits.sv
`timescale 1ns/1ps
// Scoreboard bench for vga_clock_digits: stimulus pushes expected {hs,vs,r,g,b} per strobe,
// a monitor pops and compares two strobes later.
module tb_vga_clock_digits;

  localparam logic [11:0] GRN = 12'h0F0;
  localparam logic [11:0] RED = 12'hF00;
  localparam logic [11:0] BLK = 12'h000;

  logic CLK = 1'b0;
  logic RST_BTN = 1'b0;

  vga_clock_digits_if #(.N_DIGITS(6)) bus ();

  vga_clock_digits #(.BLINK_FRAMES(2)) dut (
    .CLK     (CLK),
    .RST_BTN (RST_BTN),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int fcount  = 0;

  logic [13:0] exp_q [$];
  bit          chk_q [$];
  string       name_q [$];

  task automatic check(input string nm, input logic [13:0] got, input logic [13:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Monitor: each strobe edge retires the pixel presented one strobe earlier.
  bit          h_chk = 1'b0;
  logic [13:0] h_exp = '0;
  string       h_nm  = "";
  initial begin
    forever begin
      @(posedge CLK);
      if (bus.i_pix_stb === 1'b1 && RST_BTN === 1'b1) begin
        #1;
        if (h_chk) check(h_nm, {bus.o_hs, bus.o_vs, bus.o_r, bus.o_g, bus.o_b}, h_exp);
        if (exp_q.size() > 0) begin
          h_exp = exp_q.pop_front();
          h_chk = chk_q.pop_front();
          h_nm  = name_q.pop_front();
        end else begin
          h_chk = 1'b0;
        end
      end
    end
  end

  task automatic pix(input int x, input int y, input bit chk, input logic [11:0] rgb,
                     input string nm);
    logic [9:0] xv;
    logic [8:0] yv;
    xv = x[9:0];
    yv = y[8:0];
    @(negedge CLK);
    bus.i_pix_stb = 1'b1;
    bus.i_x  = xv;
    bus.i_y  = yv;
    bus.i_hs = xv[0];
    bus.i_vs = yv[0];
    exp_q.push_back({xv[0], yv[0], rgb});
    chk_q.push_back(chk);
    name_q.push_back(nm);
    @(negedge CLK);
    bus.i_pix_stb = 1'b0;
  endtask

  task automatic frame_start(input logic [5:0] hit);
    @(negedge CLK);
    bus.i_pix_stb = 1'b1;
    bus.i_x   = '0;
    bus.i_y   = '0;
    bus.i_hs  = 1'b0;
    bus.i_vs  = 1'b0;
    bus.i_hit = hit;
    exp_q.push_back('0);
    chk_q.push_back(1'b0);
    name_q.push_back("fs");
    fcount++;
    @(negedge CLK);
    bus.i_pix_stb = 1'b0;
    bus.i_hit     = '0;
  endtask

  task automatic hit_pulse(input logic [5:0] hit);
    @(negedge CLK);
    bus.i_hit = hit;
    @(negedge CLK);
    bus.i_hit = '0;
  endtask

  task automatic dummy();
    pix(639, 479, 1'b0, BLK, "dummy");
  endtask

  function automatic logic [11:0] col_exp();
    return (((fcount / 2) % 2) == 0) ? GRN : BLK;
  endfunction

  // Frame 1 with digits 123456: {x, y, colour}.
  int          t1x [16] = '{55, 99, 504, 504, 226, 248, 172, 129, 199, 191, 365, 600, 111, 110, 151, 151};
  int          t1y [16] = '{181, 181, 205, 250, 250, 230, 250, 250, 216, 216, 259, 400, 200, 200, 280, 281};
  logic [11:0] t1c [16] = '{BLK, GRN, BLK, GRN, BLK, GRN, BLK, GRN, GRN, BLK, GRN, BLK, BLK, GRN, GRN, BLK};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_pix_stb = 1'b0;
    bus.i_x       = '0;
    bus.i_y       = '0;
    bus.i_hs      = 1'b0;
    bus.i_vs      = 1'b0;
    bus.i_bcd     = 24'h123456;
    bus.i_blank   = '0;
    bus.i_hit     = '0;
    #1;
    check("reset_rgb", {bus.o_hs, bus.o_vs, bus.o_r, bus.o_g, bus.o_b}, 14'h0);
    repeat (3) @(negedge CLK);
    RST_BTN = 1'b1;
    fcount  = 0;

    // Before the first frame_start digits are blank, colon visible.
    pix(99, 181, 1'b1, BLK, "pre_blank_digit");
    pix(199, 216, 1'b1, GRN, "pre_colon");

    // Geometry and glyphs.
    frame_start('0);
    for (int i = 0; i < 16; i++)
      pix(t1x[i], t1y[i], 1'b1, t1c[i], $sformatf("t1_%0d_%0d", t1x[i], t1y[i]));

    // Double buffering.
    bus.i_bcd = 24'h987654;
    pix(82, 187, 1'b1, BLK, "t2_old_d5a");
    pix(483, 273, 1'b1, GRN, "t2_old_d0d");
    pix(248, 230, 1'b1, GRN, "t2_old_d3g");
    frame_start('0);
    pix(82, 187, 1'b1, GRN, "t2_new_d5a");
    pix(483, 273, 1'b1, BLK, "t2_new_d0d");
    pix(248, 230, 1'b1, BLK, "t2_new_d3g");

    // Colon blink with period 2 frames.
    pix(199, 216, 1'b1, col_exp(), "t4_colon_f2");
    while (fcount < 6) begin
      frame_start('0);
      pix(199, 216, 1'b1, col_exp(), $sformatf("t4_colon_up_f%0d", fcount));
      pix(365, 259, 1'b1, col_exp(), $sformatf("t4_colon_lo_f%0d", fcount));
    end

    // Flash on digit 0 ('4', seg c at 504,250).
    hit_pulse(6'b000001);
    pix(504, 250, 1'b1, RED, "t3_mid_hit");
    pix(483, 187, 1'b1, BLK, "t3_unlit");
    pix(414, 187, 1'b1, GRN, "t3_other_digit");
    for (int i = 1; i <= 5; i++) begin
      frame_start('0);
      pix(504, 250, 1'b1, RED, $sformatf("t3_decay_%0d", i));
    end
    frame_start(6'b000001);
    for (int i = 0; i <= 30; i++) begin
      if (i > 0) frame_start('0);
      pix(504, 250, 1'b1, (i < 30) ? RED : GRN, $sformatf("t3_reload_f%0d", i));
      pix(199, 216, 1'b1, col_exp(), $sformatf("t3_colon_f%0d", i));
    end

    // Invalid code and blanking.
    bus.i_bcd   = 24'h987B54;
    bus.i_blank = 6'b001000;
    pix(248, 187, 1'b1, GRN, "t5_old_d3a");
    frame_start('0);
    pix(248, 187, 1'b1, BLK, "t5_blank_d3a");
    pix(317, 187, 1'b1, BLK, "t5_codeB_a");
    pix(317, 230, 1'b1, BLK, "t5_codeB_g");
    pix(295, 250, 1'b1, BLK, "t5_codeB_e");
    pix(414, 187, 1'b1, GRN, "t5_d1_still");
    hit_pulse(6'b001000);
    pix(248, 187, 1'b1, BLK, "t5_blank_hit");

    // Mid-line asynchronous reset.
    bus.i_bcd   = 24'h123456;
    bus.i_blank = '0;
    frame_start('0);
    pix(99, 181, 1'b1, GRN, "t6_pre_green");
    dummy();
    check("t6_pre_direct", {bus.o_hs, bus.o_vs, bus.o_r, bus.o_g, bus.o_b}, {2'b11, GRN});
    #2;
    RST_BTN = 1'b0;
    #1;
    check("t6_async_black", {bus.o_hs, bus.o_vs, bus.o_r, bus.o_g, bus.o_b}, 14'h0);
    repeat (3) @(negedge CLK);
    RST_BTN = 1'b1;
    fcount  = 0;
    pix(99, 181, 1'b1, BLK, "t6_blank_digit");
    pix(199, 216, 1'b1, GRN, "t6_colon");
    pix(504, 250, 1'b1, BLK, "t6_blank_d0");
    frame_start('0);
    pix(99, 181, 1'b1, GRN, "t6_fs_digit");
    pix(248, 230, 1'b1, GRN, "t6_flash_cleared");
    pix(199, 216, 1'b1, col_exp(), "t6_colon_f1");
    dummy();
    dummy();

    check("sb_drain", 14'(exp_q.size()), 14'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
